// File: rtl/collectible_tracker.sv
// collectible_tracker: scans NUM_ITEMS runtime-loaded collectibles against the
// player hitbox once per frame, one item per cycle through a single shared
// comparator. Clears present bits on pickup, counts pickups and reports each
// pickup as a pulse.
//
// Optional build macro COLLECT_SCORE_EN adds a saturating 16-bit score port.
module collectible_tracker #(
  parameter int NUM_ITEMS      = 8,
  parameter int COORD_W        = 16,
  parameter int HB_X_LO        = 90,
  parameter int HB_X_HI        = 110,
  parameter int HB_Y_LO        = 20,
  parameter int HB_Y_HI        = 80,
  parameter int ITEM_HALF      = 16,
  parameter int SCORE_PER_ITEM = 1,
  localparam int IDX_W         = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1,
  localparam int CNT_W         = $clog2(NUM_ITEMS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] X,
  input  logic [COORD_W-1:0] Y,
  input  logic               frame_start,
  input  logic               load_en,
  input  logic [IDX_W-1:0]   load_idx,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  input  logic               rearm_all,
  output logic [NUM_ITEMS-1:0] present,
  output logic [CNT_W-1:0]   collected_count,
  output logic               collect_pulse,
  output logic [IDX_W-1:0]   collect_idx,
  output logic               scan_busy,
  output logic               scan_done,
  output logic               all_collected
`ifdef COLLECT_SCORE_EN
  ,
  output logic [15:0]        score
`endif
);

  // Two guard bits keep every sum and difference of the hit test free of wrap.
  localparam int EXT_W = COORD_W + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ITEMS - 1);

  if (NUM_ITEMS < 1 || NUM_ITEMS > 64 || SCORE_PER_ITEM < 0) begin : g_bad_param
    $error("collectible_tracker: NUM_ITEMS must be 1..64 and SCORE_PER_ITEM >= 0");
  end

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   scan_idx;
  logic               pending;
  logic [COORD_W-1:0] px;
  logic [COORD_W-1:0] py;

  logic [COORD_W-1:0] pos_x [NUM_ITEMS];
  logic [COORD_W-1:0] pos_y [NUM_ITEMS];

  logic               load_ok;
  logic               hit;
  logic               do_collect;
  logic [EXT_W-1:0]   cx, cy, x_lo, x_hi, y_lo, y_hi;

  assign load_ok = load_en && (int'(load_idx) < NUM_ITEMS);

  // Position storage: one X/Y pair per item, written by load_en.
  // NOTE: storage arrays are deliberately left out of reset; their contents are
  // don't-care until loaded, and a reset net per bit would only cost fan-out.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      pos_x[load_idx] <= load_x;
      pos_y[load_idx] <= load_y;
    end
  end

  // Scan sequencer: IDLE -> SCAN (one item per cycle) -> DONE, with a one-deep
  // pending request so a frame_start arriving mid-scan is not lost.
  // NOTE: every state register here uses <= so all updates see pre-edge values;
  // a blocking = would let later statements observe half-updated state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      scan_idx  <= '0;
      pending   <= 1'b0;
      px        <= '0;
      py        <= '0;
      scan_busy <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (frame_start) begin
            px        <= X;
            py        <= Y;
            scan_idx  <= '0;
            scan_busy <= 1'b1;
            state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (frame_start) pending <= 1'b1;
          if (scan_idx == LAST_IDX) begin
            scan_done <= 1'b1;
            state     <= S_DONE;
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          // A queued or same-cycle request starts the next scan right away.
          if (pending || frame_start) begin
            pending   <= 1'b0;
            px        <= X;
            py        <= Y;
            scan_idx  <= '0;
            state     <= S_SCAN;
          end else begin
            scan_busy <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Shared comparator: tests the item at scan_idx against the latched hitbox.
  // NOTE: every output of this block is assigned before any condition, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    cx   = EXT_W'(pos_x[scan_idx]) + EXT_W'(ITEM_HALF);
    cy   = EXT_W'(pos_y[scan_idx]) - EXT_W'(ITEM_HALF);
    x_lo = EXT_W'(px) + EXT_W'(HB_X_LO);
    x_hi = EXT_W'(px) + EXT_W'(HB_X_HI);
    y_lo = EXT_W'(py) + EXT_W'(HB_Y_LO);
    y_hi = EXT_W'(py) + EXT_W'(HB_Y_HI);
    hit  = 1'b0;
    // cy's top bit set means the anchor sits above ITEM_HALF: never a hit.
    if (state == S_SCAN && !cy[EXT_W-1]) begin
      hit = (cx >= x_lo) && (cx <= x_hi) && (cy >= y_lo) && (cy <= y_hi);
    end
  end

  // A pickup needs an uncollected item, and loses to rearm_all and to a load
  // of the same slot in the same cycle.
  assign do_collect = hit && present[scan_idx] && !rearm_all &&
                      !(load_ok && (load_idx == scan_idx));

  // Present bits, pickup count and pickup reporting; later assignments win,
  // giving rearm_all > load_en > collection on the present bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      present         <= '1;
      collected_count <= '0;
      collect_pulse   <= 1'b0;
      collect_idx     <= '0;
      all_collected   <= 1'b0;
    end else begin
      collect_pulse <= 1'b0;
      all_collected <= (present == '0);
      if (do_collect) begin
        present[scan_idx] <= 1'b0;
        collect_pulse     <= 1'b1;
        collect_idx       <= scan_idx;
        if (collected_count != CNT_W'(NUM_ITEMS)) begin
          collected_count <= collected_count + CNT_W'(1);
        end
      end
      if (load_ok) present[load_idx] <= 1'b1;
      if (rearm_all) begin
        present         <= '1;
        collected_count <= '0;
      end
    end
  end

`ifdef COLLECT_SCORE_EN
  logic [16:0] score_sum;
  assign score_sum = {1'b0, score} + 17'(SCORE_PER_ITEM);

  // Saturating pickup score; only reset clears it, rearm_all leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      score <= '0;
    end else if (do_collect) begin
      score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end
`else
  // Without COLLECT_SCORE_EN there is no score register and no score adder.
`endif

endmodule

// File: tb/tb_collectible_tracker.sv
// Self-checking bench for collectible_tracker (default parameters). A reference
// model predicts which items each scan collects; predictions go into a queue
// that a negedge monitor drains as collect_pulse events appear.
module tb_collectible_tracker;

  localparam int N         = 8;
  localparam int SCAN_TICK = 8;   // ticks from the first SCAN cycle to DONE

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] X, Y;
  logic        frame_start;
  logic        load_en;
  logic [2:0]  load_idx;
  logic [15:0] load_x, load_y;
  logic        rearm_all;
  wire  [7:0]  present;
  wire  [3:0]  collected_count;
  wire         collect_pulse;
  wire  [2:0]  collect_idx;
  wire         scan_busy;
  wire         scan_done;
  wire         all_collected;
`ifdef COLLECT_SCORE_EN
  wire  [15:0] score;
`endif

  collectible_tracker dut (
    .clk(clk), .reset(reset), .X(X), .Y(Y), .frame_start(frame_start),
    .load_en(load_en), .load_idx(load_idx), .load_x(load_x), .load_y(load_y),
    .rearm_all(rearm_all), .present(present), .collected_count(collected_count),
    .collect_pulse(collect_pulse), .collect_idx(collect_idx),
    .scan_busy(scan_busy), .scan_done(scan_done), .all_collected(all_collected)
`ifdef COLLECT_SCORE_EN
    , .score(score)
`endif
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int exp_q[$];
  int mon_e;

  // Reference model state
  logic [7:0] m_pres;
  int         m_cnt;
  int         m_score;
  int         m_x [N];
  int         m_y [N];

  // Scoreboard drain: every collect_pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (collect_pulse === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL collect_unexpected got idx %0d, want no collection", collect_idx);
      end else begin
        mon_e = exp_q.pop_front();
        if (collect_idx !== 3'(mon_e))
          $display("FAIL collect_idx got %0d want %0d", collect_idx, mon_e);
        else passed++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time exceeded, got no finish, want finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic bit model_hit(input int ix, input int iy, input int px, input int py);
    int cx, cy;
    cx = ix + 16;
    cy = iy - 16;
    if (cy < 0) return 1'b0;
    return (cx >= px + 90) && (cx <= px + 110) && (cy >= py + 20) && (cy <= py + 80);
  endfunction

  function automatic void model_collect(input int i);
    exp_q.push_back(i);
    m_pres[i] = 1'b0;
    if (m_cnt < N) m_cnt++;
    m_score = (m_score >= 16'hFFFF) ? 16'hFFFF : m_score + 1;
  endfunction

  function automatic void expect_scan(input int px, input int py);
    for (int i = 0; i < N; i++)
      if (m_pres[i] && model_hit(m_x[i], m_y[i], px, py)) model_collect(i);
  endfunction

  task automatic load(input int idx, input int x, input int y);
    load_en = 1'b1; load_idx = 3'(idx); load_x = 16'(x); load_y = 16'(y);
    tick(1);
    load_en = 1'b0;
    m_x[idx] = x; m_y[idx] = y; m_pres[idx] = 1'b1;
  endtask

  task automatic rearm();
    rearm_all = 1'b1; tick(1); rearm_all = 1'b0;
    m_pres = 8'hFF; m_cnt = 0;
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (scan_done !== 1'b1 && n < 40) begin tick(1); n++; end
    if (scan_done !== 1'b1) begin
      total++;
      $display("FAIL %s_timeout got no scan_done within 40 cycles, want scan_done", tag);
    end
  endtask

  task automatic check_state(input string tag);
    total++;
    if (exp_q.size() != 0) $display("FAIL %s_pending got %0d outstanding collections want 0", tag, exp_q.size());
    else passed++;
    total++;
    if (present !== m_pres) $display("FAIL %s_present got %h want %h", tag, present, m_pres);
    else passed++;
    total++;
    if (collected_count !== 4'(m_cnt)) $display("FAIL %s_count got %0d want %0d", tag, collected_count, m_cnt);
    else passed++;
  endtask

  // Full scan at player (px,py); checks latency and end-of-scan state.
  task automatic run_scan(input int px, input int py, input string tag);
    int n;
    X = 16'(px); Y = 16'(py);
    expect_scan(px, py);
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    wait_done(tag, n);
    total++;
    if (n != SCAN_TICK) $display("FAIL %s_latency got %0d want %0d", tag, n + 1, SCAN_TICK + 1);
    else passed++;
    tick(1);
    check_state(tag);
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(2); reset = 1'b0;
    m_pres = 8'hFF; m_cnt = 0; m_score = 0;
    total++; if (present !== 8'hFF) $display("FAIL reset_present got %h want ff", present); else passed++;
    total++; if (collected_count !== 4'd0) $display("FAIL reset_count got %0d want 0", collected_count); else passed++;
    total++; if (scan_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", scan_busy); else passed++;
    total++; if (scan_done !== 1'b0) $display("FAIL reset_done got %b want 0", scan_done); else passed++;
    total++; if (collect_pulse !== 1'b0) $display("FAIL reset_pulse got %b want 0", collect_pulse); else passed++;
    total++; if (all_collected !== 1'b0) $display("FAIL reset_all_collected got %b want 0", all_collected); else passed++;
`ifdef COLLECT_SCORE_EN
    total++; if (score !== 16'd0) $display("FAIL reset_score got %0d want 0", score); else passed++;
`endif
  endtask

  task automatic test_single();
    int n;
    for (int i = 0; i < N; i++) load(i, 0, 0);   // cy < 0: never hits
    load(0, 946, 255);
    X = 16'd870; Y = 16'd200;
    expect_scan(870, 200);
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    total++; if (scan_busy !== 1'b1) $display("FAIL single_busy got %b want 1", scan_busy); else passed++;
    total++; if (present !== 8'hFF) $display("FAIL single_present_early got %h want ff", present); else passed++;
    tick(1);
    total++; if (present !== 8'hFE) $display("FAIL single_present got %h want fe", present); else passed++;
    total++;
    if (collect_pulse !== 1'b1 || collect_idx !== 3'd0)
      $display("FAIL single_pulse got pulse %b idx %0d want pulse 1 idx 0", collect_pulse, collect_idx);
    else passed++;
    total++; if (collected_count !== 4'd1) $display("FAIL single_count got %0d want 1", collected_count); else passed++;
    wait_done("single", n);
    total++; if (n + 1 != SCAN_TICK) $display("FAIL single_latency got %0d want %0d", n + 2, SCAN_TICK + 1); else passed++;
    tick(1);
    total++;
    if (scan_busy !== 1'b0 || scan_done !== 1'b0)
      $display("FAIL single_idle got busy %b done %b want 0 0", scan_busy, scan_done);
    else passed++;
    check_state("single");
  endtask

  task automatic test_boundary();
    int xs [9] = '{853, 852, 851, 872, 873, 870, 870, 870, 870};
    int ys [9] = '{200, 200, 200, 200, 200, 159, 158, 219, 220};
    load(2, 946, 10);   // cy negative even though X is in range
    for (int k = 0; k < 9; k++) begin
      rearm();
      run_scan(xs[k], ys[k], $sformatf("boundary%0d", k));
    end
    load(2, 0, 0);
  endtask

  task automatic test_pair();
    rearm();
    load(1, 946, 255);
    X = 16'd870; Y = 16'd200;
    expect_scan(870, 200);
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    tick(1);
    total++;
    if (collect_pulse !== 1'b1 || collect_idx !== 3'd0)
      $display("FAIL pair_first got pulse %b idx %0d want 1 0", collect_pulse, collect_idx);
    else passed++;
    tick(1);
    total++;
    if (collect_pulse !== 1'b1 || collect_idx !== 3'd1)
      $display("FAIL pair_second got pulse %b idx %0d want 1 1", collect_pulse, collect_idx);
    else passed++;
    begin int n; wait_done("pair", n); end
    tick(1);
    check_state("pair");
  endtask

  task automatic test_back_to_back();
    int n;
    bit  extra;
    rearm();
    X = 16'd870; Y = 16'd200;
    expect_scan(870, 200);
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    tick(2);
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    tick(1);
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    wait_done("b2b_first", n);
    tick(1);
    total++;
    if (scan_busy !== 1'b1 || scan_done !== 1'b0)
      $display("FAIL b2b_restart got busy %b done %b want 1 0", scan_busy, scan_done);
    else passed++;
    expect_scan(870, 200);
    wait_done("b2b_second", n);
    total++; if (n != SCAN_TICK) $display("FAIL b2b_latency got %0d want %0d", n, SCAN_TICK); else passed++;
    tick(1);
    total++; if (scan_busy !== 1'b0) $display("FAIL b2b_idle got busy %b want 0", scan_busy); else passed++;
    extra = 1'b0;
    for (int i = 0; i < 12; i++) begin tick(1); if (scan_busy !== 1'b0) extra = 1'b1; end
    total++; if (extra) $display("FAIL b2b_third_scan got extra scan want none"); else passed++;
    check_state("b2b");
  endtask

  task automatic test_simultaneous();
    int n;
    // rearm_all in the item-0 test cycle: rearm wins, scan continues to item 1
    rearm();
    X = 16'd870; Y = 16'd200;
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    rearm_all = 1'b1; tick(1); rearm_all = 1'b0;
    m_pres = 8'hFF; m_cnt = 0;
    model_collect(1);
    wait_done("sim_rearm", n);
    tick(1);
    check_state("sim_rearm");
    // load of slot 0 in its own test cycle: load wins, count unchanged
    rearm();
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    load(0, 946, 255);
    model_collect(1);
    wait_done("sim_load", n);
    tick(1);
    check_state("sim_load");
  endtask

  task automatic test_collect_all();
    rearm();
    for (int i = 0; i < N; i++) load(i, 946, 255);
    run_scan(870, 200, "all");
    total++; if (all_collected !== 1'b1) $display("FAIL all_rise got %b want 1", all_collected); else passed++;
`ifdef COLLECT_SCORE_EN
    total++; if (score !== 16'(m_score)) $display("FAIL all_score got %0d want %0d", score, m_score); else passed++;
`endif
    rearm();
    total++; if (all_collected !== 1'b1) $display("FAIL all_lag got %b want 1", all_collected); else passed++;
    tick(1);
    total++; if (all_collected !== 1'b0) $display("FAIL all_fall got %b want 0", all_collected); else passed++;
    check_state("all_rearm");
`ifdef COLLECT_SCORE_EN
    total++; if (score !== 16'(m_score)) $display("FAIL all_score_kept got %0d want %0d", score, m_score); else passed++;
`endif
  endtask

  task automatic test_reset_midscan();
    bit done_seen;
    X = 16'd870; Y = 16'd200;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    tick(3);   // item 3 under test now
    reset = 1'b1; tick(1);
    m_pres = 8'hFF; m_cnt = 0; m_score = 0;
    total++; if (scan_busy !== 1'b0) $display("FAIL midreset_busy got %b want 0", scan_busy); else passed++;
    total++; if (scan_done !== 1'b0) $display("FAIL midreset_done got %b want 0", scan_done); else passed++;
    total++; if (collect_pulse !== 1'b0) $display("FAIL midreset_pulse got %b want 0", collect_pulse); else passed++;
    check_state("midreset");
`ifdef COLLECT_SCORE_EN
    total++; if (score !== 16'd0) $display("FAIL midreset_score got %0d want 0", score); else passed++;
`endif
    reset = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (scan_done !== 1'b0 || scan_busy !== 1'b0) done_seen = 1'b1;
    end
    total++; if (done_seen) $display("FAIL midreset_resume got scan activity want none"); else passed++;
  endtask

  initial begin
    reset = 1'b1; X = '0; Y = '0; frame_start = 1'b0; load_en = 1'b0;
    load_idx = '0; load_x = '0; load_y = '0; rearm_all = 1'b0;
    m_pres = 8'hFF; m_cnt = 0; m_score = 0;
    for (int i = 0; i < N; i++) begin m_x[i] = 0; m_y[i] = 0; end
    test_reset();
    test_single();
    test_boundary();
    test_pair();
    test_back_to_back();
    test_simultaneous();
    test_collect_all();
    test_reset_midscan();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
